// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, fetch FSM states and the
// decoded-opcode payload used by the fetch sequencer and execute stage.
package cpu_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned OPC_W   = 3;
  localparam int unsigned DEPTH_W = 4;

  localparam logic [OPC_W-1:0] OP_HLT  = 3'b000;
  localparam logic [OPC_W-1:0] OP_NOP  = 3'b001;
  localparam logic [OPC_W-1:0] OP_ALU  = 3'b010;
  localparam logic [OPC_W-1:0] OP_LDA  = 3'b011;
  localparam logic [OPC_W-1:0] OP_STO  = 3'b100;
  localparam logic [OPC_W-1:0] OP_JMP  = 3'b101;
  localparam logic [OPC_W-1:0] OP_CALL = 3'b110;
  localparam logic [OPC_W-1:0] OP_RET  = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_OPER   = 3'd2,
    ST_BRANCH = 3'd3,
    ST_RETURN = 3'd4,
    ST_ISSUE  = 3'd5,
    ST_HALT   = 3'd6
  } fetch_state_t;

  typedef struct packed {
    logic two_byte;
    logic is_branch;
    logic is_call;
    logic is_ret;
    logic is_halt;
  } dec_t;

  function automatic logic is_two_byte(input logic [OPC_W-1:0] opcode);
    return (opcode == OP_LDA) || (opcode == OP_STO) ||
           (opcode == OP_JMP) || (opcode == OP_CALL);
  endfunction

endpackage

// File: rtl/fetch_decode.sv
// Combinational opcode classifier used by the fetch sequencer.
module fetch_decode
  import cpu_pkg::*;
(
  input  logic [OPC_W-1:0] i_opcode,
  output dec_t             o_dec
);

  always_comb begin
    o_dec           = '0;
    o_dec.two_byte  = is_two_byte(i_opcode);
    o_dec.is_branch = (i_opcode == OP_JMP) || (i_opcode == OP_CALL);
    o_dec.is_call   = (i_opcode == OP_CALL);
    o_dec.is_ret    = (i_opcode == OP_RET);
    o_dec.is_halt   = (i_opcode == OP_HLT);
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: reads ROM bytes, resolves JMP/CALL/RET by
// commanding the program counter and hands other instructions to execute.
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic               clock,
  input  logic               rst,
  input  logic [DATA_W-1:0]  pc_addr,
  input  logic [DATA_W-1:0]  mem_data,
  output logic               mem_rd,
  input  logic               stall,
  output logic               pc_en,
  output logic               pc_wr,
  output logic               pc_acall,
  output logic [DATA_W-1:0]  pc_data,
  output logic [DATA_W-1:0]  ir,
  output logic [DATA_W-1:0]  operand,
  output logic               ins_valid,
  input  logic               exec_done,
  output logic [DEPTH_W-1:0] depth,
  output logic               halted,
  output logic               err
);

  fetch_state_t       r_state;
  fetch_state_t       w_state_nxt;
  logic [DATA_W-1:0]  r_ir;
  logic [DATA_W-1:0]  w_ir_nxt;
  logic [DATA_W-1:0]  r_operand;
  logic [DATA_W-1:0]  w_operand_nxt;
  logic [DEPTH_W-1:0] r_depth;
  logic [DEPTH_W-1:0] w_depth_nxt;
  logic               r_err;
  logic               w_err_nxt;
  logic [OPC_W-1:0]   w_opcode;
  dec_t               w_dec;
  logic               w_stack_full;
  logic               w_stack_empty;
  logic               w_pc_addr_unused;

  // The counter tracks its own address; it is exposed here for debug only.
  assign w_pc_addr_unused = ^pc_addr;

  // Decode the live ROM byte in FETCH, the held IR everywhere else.
  assign w_opcode = (r_state == ST_FETCH) ? mem_data[7:5] : r_ir[7:5];

  fetch_decode u_decode (
    .i_opcode (w_opcode),
    .o_dec    (w_dec)
  );

  assign w_stack_full  = (r_depth == DEPTH_W'(STACK_DEPTH));
  assign w_stack_empty = (r_depth == '0);

  always_ff @(posedge clock) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_ir      <= '0;
      r_operand <= '0;
      r_depth   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ir      <= w_ir_nxt;
      r_operand <= w_operand_nxt;
      r_depth   <= w_depth_nxt;
      r_err     <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ir_nxt      = r_ir;
    w_operand_nxt = r_operand;
    w_depth_nxt   = r_depth;
    w_err_nxt     = r_err;
    mem_rd        = 1'b0;
    pc_en         = 1'b0;
    pc_wr         = 1'b0;
    pc_acall      = 1'b0;
    pc_data       = '0;
    ins_valid     = 1'b0;
    halted        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_FETCH;
      end

      ST_FETCH: begin
        if (!stall) begin
          mem_rd   = 1'b1;
          pc_en    = 1'b1;
          w_ir_nxt = mem_data;
          if (w_dec.two_byte) begin
            w_state_nxt = ST_OPER;
          end else if (w_dec.is_ret) begin
            // Popping an empty return stack is fatal: flag and stop.
            if (w_stack_empty) begin
              w_err_nxt   = 1'b1;
              w_state_nxt = ST_HALT;
            end else begin
              w_state_nxt = ST_RETURN;
            end
          end else if (w_dec.is_halt) begin
            w_state_nxt = ST_HALT;
          end else if (w_opcode == OP_NOP) begin
            w_state_nxt = ST_FETCH;
          end else begin
            w_state_nxt = ST_ISSUE;
          end
        end
      end

      ST_OPER: begin
        if (!stall) begin
          mem_rd        = 1'b1;
          w_operand_nxt = mem_data;
          // Branches leave PC on the operand byte so CALL pushes the next opcode.
          if (w_dec.is_branch) begin
            if (w_dec.is_call && w_stack_full) begin
              w_err_nxt   = 1'b1;
              w_state_nxt = ST_HALT;
            end else begin
              w_state_nxt = ST_BRANCH;
            end
          end else begin
            pc_en       = 1'b1;
            w_state_nxt = ST_ISSUE;
          end
        end
      end

      ST_BRANCH: begin
        pc_wr       = 1'b1;
        pc_data     = r_operand;
        pc_acall    = w_dec.is_call;
        w_state_nxt = ST_FETCH;
        if (w_dec.is_call) begin
          w_depth_nxt = r_depth + DEPTH_W'(1);
        end
      end

      ST_RETURN: begin
        pc_acall    = 1'b1;
        w_depth_nxt = r_depth - DEPTH_W'(1);
        w_state_nxt = ST_FETCH;
      end

      ST_ISSUE: begin
        ins_valid = 1'b1;
        if (exec_done) begin
          w_state_nxt = ST_FETCH;
        end
      end

      ST_HALT: begin
        halted = 1'b1;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign ir      = r_ir;
  assign operand = r_operand;
  assign depth   = r_depth;
  assign err     = r_err;

  // Counter command is exclusive: increment, load, or pop.
  a_pc_cmd_onehot: assert property (@(posedge clock) disable iff (!rst)
    $onehot0({pc_en, pc_wr, pc_acall & ~pc_wr}));

  a_depth_bound: assert property (@(posedge clock) disable iff (!rst)
    r_depth <= DEPTH_W'(STACK_DEPTH));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: ROM plus program-counter model, directed scenarios and
// randomized programs checked against an instruction-level reference.
module tb_fetch_ctrl;

  logic       clock = 1'b0;
  logic       rst;
  logic [7:0] pc_addr;
  logic [7:0] mem_data;
  logic       mem_rd;
  logic       stall;
  logic       pc_en;
  logic       pc_wr;
  logic       pc_acall;
  logic [7:0] pc_data;
  logic [7:0] ir;
  logic [7:0] operand;
  logic       ins_valid;
  logic       exec_done;
  logic [3:0] depth;
  logic       halted;
  logic       err;

  logic [7:0] rom [256];
  logic [7:0] stk [8];
  int         sp;

  int errors    = 0;
  int checks    = 0;
  int inv_viol  = 0;

  always #5 clock = ~clock;

  fetch_ctrl #(.STACK_DEPTH(8)) dut (
    .clock     (clock),
    .rst       (rst),
    .pc_addr   (pc_addr),
    .mem_data  (mem_data),
    .mem_rd    (mem_rd),
    .stall     (stall),
    .pc_en     (pc_en),
    .pc_wr     (pc_wr),
    .pc_acall  (pc_acall),
    .pc_data   (pc_data),
    .ir        (ir),
    .operand   (operand),
    .ins_valid (ins_valid),
    .exec_done (exec_done),
    .depth     (depth),
    .halted    (halted),
    .err       (err)
  );

  assign mem_data = rom[pc_addr];

  // Program counter with 8-entry return stack, sharing the sequencer reset.
  always @(posedge clock) begin
    if (!rst) begin
      pc_addr <= 8'h00;
      sp      <= 0;
    end else if (pc_wr) begin
      if (pc_acall) begin
        stk[3'(sp)] <= pc_addr + 8'd1;
        sp          <= sp + 1;
      end
      pc_addr <= pc_data;
    end else if (pc_acall) begin
      pc_addr <= stk[3'(sp - 1)];
      sp      <= sp - 1;
    end else if (pc_en) begin
      pc_addr <= pc_addr + 8'd1;
    end
  end

  always @(negedge clock) begin
    if (rst === 1'b1 &&
        (int'(pc_en) + int'(pc_wr) + int'(pc_acall & ~pc_wr)) > 1)
      inv_viol++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_rom;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset;
    rst       = 1'b0;
    stall     = 1'b0;
    exec_done = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset;
    clear_rom();
    do_reset();
    checks++;
    if ({mem_rd, pc_en, pc_wr, pc_acall, ins_valid, halted, err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {mem_rd, pc_en, pc_wr, pc_acall, ins_valid, halted, err});
    end
    checks++;
    if ({pc_data, ir, operand} !== 24'h0) begin
      errors++;
      $display("FAIL reset_regs: got pc_data/ir/operand %h expected 000000",
               {pc_data, ir, operand});
    end
    checks++;
    if (depth !== 4'd0) begin
      errors++;
      $display("FAIL reset_depth: got %0d expected 0", depth);
    end
  endtask

  task automatic test_alu;
    clear_rom();
    rom[0] = 8'h40;
    do_reset();
    exec_done = 1'b1;
    tick();
    checks++;
    if ({mem_rd, pc_en, ins_valid, pc_addr} !== {3'b110, 8'h00}) begin
      errors++;
      $display("FAIL alu_fetch: got rd/en/valid/pc %b/%h expected 110/00",
               {mem_rd, pc_en, ins_valid}, pc_addr);
    end
    tick();
    checks++;
    if ({ins_valid, pc_en, ir} !== {2'b10, 8'h40}) begin
      errors++;
      $display("FAIL alu_issue: got valid/en/ir %b/%h expected 10/40",
               {ins_valid, pc_en}, ir);
    end
    tick();
    checks++;
    if ({mem_rd, ins_valid, pc_addr} !== {2'b10, 8'h01}) begin
      errors++;
      $display("FAIL alu_next: got rd/valid/pc %b/%h expected 10/01",
               {mem_rd, ins_valid}, pc_addr);
    end
  endtask

  task automatic test_jmp;
    clear_rom();
    rom[0] = 8'hA0;
    rom[1] = 8'h10;
    do_reset();
    exec_done = 1'b1;
    tick();
    tick();
    checks++;
    if ({mem_rd, pc_en, pc_wr} !== 3'b100) begin
      errors++;
      $display("FAIL jmp_oper: got rd/en/wr %b expected 100", {mem_rd, pc_en, pc_wr});
    end
    tick();
    checks++;
    if ({pc_wr, pc_acall, pc_en, pc_data} !== {3'b100, 8'h10}) begin
      errors++;
      $display("FAIL jmp_branch: got wr/acall/en/data %b/%h expected 100/10",
               {pc_wr, pc_acall, pc_en}, pc_data);
    end
    tick();
    checks++;
    if ({mem_rd, pc_addr, depth} !== {1'b1, 8'h10, 4'd0}) begin
      errors++;
      $display("FAIL jmp_target: got rd/pc/depth %b/%h/%0d expected 1/10/0",
               mem_rd, pc_addr, depth);
    end
  endtask

  task automatic test_call_ret;
    clear_rom();
    for (int i = 0; i < 4; i++) rom[i] = 8'h20;
    rom[4]     = 8'hC0;
    rom[5]     = 8'h20;
    rom[8'h20] = 8'hE0;
    do_reset();
    exec_done = 1'b1;
    repeat (4) tick();
    checks++;
    if ({mem_rd, pc_addr} !== {1'b1, 8'h03}) begin
      errors++;
      $display("FAIL nop_rate: got rd/pc %b/%h expected 1/03", mem_rd, pc_addr);
    end
    repeat (3) tick();
    checks++;
    if ({pc_wr, pc_acall, pc_data, depth} !== {2'b11, 8'h20, 4'd0}) begin
      errors++;
      $display("FAIL call_branch: got wr/acall/data/depth %b/%h/%0d expected 11/20/0",
               {pc_wr, pc_acall}, pc_data, depth);
    end
    tick();
    checks++;
    if ({pc_addr, depth} !== {8'h20, 4'd1}) begin
      errors++;
      $display("FAIL call_target: got pc/depth %h/%0d expected 20/1", pc_addr, depth);
    end
    tick();
    checks++;
    if ({pc_acall, pc_wr, pc_en} !== 3'b100) begin
      errors++;
      $display("FAIL ret_cmd: got acall/wr/en %b expected 100", {pc_acall, pc_wr, pc_en});
    end
    tick();
    checks++;
    if ({pc_addr, depth} !== {8'h06, 4'd0}) begin
      errors++;
      $display("FAIL ret_target: got pc/depth %h/%0d expected 06/0", pc_addr, depth);
    end
    tick();
    checks++;
    if ({halted, err} !== 2'b10) begin
      errors++;
      $display("FAIL hlt_state: got halted/err %b expected 10", {halted, err});
    end
  endtask

  task automatic test_overflow;
    int wr_cnt;
    clear_rom();
    for (int k = 0; k < 9; k++) begin
      rom[2*k]     = 8'hC0;
      rom[2*k + 1] = 8'(2*k + 2);
    end
    do_reset();
    wr_cnt = 0;
    repeat (40) begin
      tick();
      if (pc_wr === 1'b1) wr_cnt++;
    end
    checks++;
    if (wr_cnt != 8) begin
      errors++;
      $display("FAIL ovf_pushes: got %0d pc_wr pulses expected 8", wr_cnt);
    end
    checks++;
    if ({halted, err, depth} !== {2'b11, 4'd8}) begin
      errors++;
      $display("FAIL ovf_state: got halted/err/depth %b/%0d expected 11/8",
               {halted, err}, depth);
    end
    checks++;
    if ({pc_addr, operand} !== {8'h11, 8'h12}) begin
      errors++;
      $display("FAIL ovf_pc: got pc/operand %h/%h expected 11/12", pc_addr, operand);
    end
  endtask

  task automatic test_underflow;
    int pop_cnt;
    clear_rom();
    rom[0] = 8'hE0;
    do_reset();
    pop_cnt = 0;
    repeat (6) begin
      tick();
      if (pc_acall === 1'b1) pop_cnt++;
    end
    checks++;
    if (pop_cnt != 0) begin
      errors++;
      $display("FAIL udf_pops: got %0d pc_acall pulses expected 0", pop_cnt);
    end
    checks++;
    if ({halted, err, depth, pc_addr} !== {2'b11, 4'd0, 8'h01}) begin
      errors++;
      $display("FAIL udf_state: got halted/err/depth/pc %b/%0d/%h expected 11/0/01",
               {halted, err}, depth, pc_addr);
    end
  endtask

  task automatic test_stall;
    int hold_cnt;
    clear_rom();
    rom[0] = 8'h60;
    rom[1] = 8'h33;
    do_reset();
    tick();
    tick();
    stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({mem_rd, pc_en, pc_wr, pc_acall, operand, pc_addr} !== {4'b0000, 8'h00, 8'h01}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got rd/en/wr/acall/operand/pc %b/%h/%h expected 0000/00/01",
                 i, {mem_rd, pc_en, pc_wr, pc_acall}, operand, pc_addr);
      end
      tick();
    end
    stall = 1'b0;
    #1;
    checks++;
    if ({mem_rd, pc_en} !== 2'b11) begin
      errors++;
      $display("FAIL stall_release: got rd/en %b expected 11", {mem_rd, pc_en});
    end
    tick();
    checks++;
    if ({ins_valid, operand, pc_addr} !== {1'b1, 8'h33, 8'h02}) begin
      errors++;
      $display("FAIL lda_issue: got valid/operand/pc %b/%h/%h expected 1/33/02",
               ins_valid, operand, pc_addr);
    end
    hold_cnt = 0;
    repeat (3) begin
      tick();
      if (ins_valid === 1'b1) hold_cnt++;
    end
    checks++;
    if (hold_cnt != 3) begin
      errors++;
      $display("FAIL valid_hold: got %0d cycles expected 3", hold_cnt);
    end
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    checks++;
    if ({ins_valid, mem_rd, pc_addr} !== {2'b01, 8'h02}) begin
      errors++;
      $display("FAIL lda_done: got valid/rd/pc %b/%h expected 01/02",
               {ins_valid, mem_rd}, pc_addr);
    end
  endtask

  task automatic test_reset_mid;
    clear_rom();
    rom[0] = 8'h40;
    do_reset();
    tick();
    tick();
    checks++;
    if (ins_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_issue: got ins_valid %b expected 1", ins_valid);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({mem_rd, pc_en, pc_wr, pc_acall, ins_valid, halted, err, depth, ir} !==
        {7'b0, 4'd0, 8'h00}) begin
      errors++;
      $display("FAIL rstmid_issue_clr: got ctrl/depth/ir %b/%0d/%h expected 0000000/0/00",
               {mem_rd, pc_en, pc_wr, pc_acall, ins_valid, halted, err}, depth, ir);
    end
    rst = 1'b1;

    clear_rom();
    rom[0] = 8'hC0;
    rom[1] = 8'h20;
    do_reset();
    repeat (3) tick();
    checks++;
    if ({pc_wr, pc_acall} !== 2'b11) begin
      errors++;
      $display("FAIL rstmid_branch: got wr/acall %b expected 11", {pc_wr, pc_acall});
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({mem_rd, pc_en, pc_wr, pc_acall, ins_valid, halted, err, depth, pc_data, pc_addr} !==
        {7'b0, 4'd0, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL rstmid_branch_clr: got ctrl/depth/data/pc %b/%0d/%h/%h expected 0000000/0/00/00",
               {mem_rd, pc_en, pc_wr, pc_acall, ins_valid, halted, err}, depth, pc_data, pc_addr);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({mem_rd, pc_addr, depth} !== {1'b1, 8'h00, 4'd0}) begin
      errors++;
      $display("FAIL rstmid_restart: got rd/pc/depth %b/%h/%0d expected 1/00/0",
               mem_rd, pc_addr, depth);
    end
  endtask

  // Random programs; the reference runs them instruction by instruction.
  task automatic test_random(input int n_prog);
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    logic [7:0]  m_stk[$];
    logic [7:0]  m_pc, m_ir, m_opnd;
    logic [2:0]  op;
    int          m_depth, m_cyc, n, cyc;
    bit          m_halt, m_err, done;
    int unsigned sel;

    for (int p = 0; p < n_prog; p++) begin
      for (int i = 0; i < 256; i++) begin
        sel = $urandom_range(0, 15);
        if (sel == 0)       op = 3'b000;
        else if (sel <= 3)  op = 3'b001;
        else if (sel <= 6)  op = 3'b010;
        else if (sel <= 8)  op = 3'b011;
        else if (sel <= 10) op = 3'b100;
        else if (sel == 11) op = 3'b101;
        else if (sel <= 13) op = 3'b110;
        else                op = 3'b111;
        rom[i] = {op, 5'($urandom)};
      end

      exp_q.delete();
      m_stk.delete();
      m_pc = 8'h00; m_opnd = 8'h00; m_depth = 0;
      m_halt = 1'b0; m_err = 1'b0; m_cyc = 1; n = 0;
      while (!m_halt && n < 80) begin
        m_ir = rom[m_pc];
        m_pc = m_pc + 8'd1;
        n++;
        case (m_ir[7:5])
          3'b000: begin m_halt = 1'b1; m_cyc += 1; end
          3'b001: m_cyc += 1;
          3'b010: begin exp_q.push_back({m_ir, m_opnd}); m_cyc += 2; end
          3'b011, 3'b100: begin
            m_opnd = rom[m_pc];
            m_pc   = m_pc + 8'd1;
            exp_q.push_back({m_ir, m_opnd});
            m_cyc += 3;
          end
          3'b101: begin m_opnd = rom[m_pc]; m_pc = m_opnd; m_cyc += 3; end
          3'b110: begin
            m_opnd = rom[m_pc];
            if (m_depth == 8) begin
              m_err = 1'b1; m_halt = 1'b1; m_cyc += 2;
            end else begin
              m_stk.push_back(m_pc + 8'd1);
              m_pc = m_opnd;
              m_depth++;
              m_cyc += 3;
            end
          end
          default: begin
            if (m_depth == 0) begin
              m_err = 1'b1; m_halt = 1'b1; m_cyc += 1;
            end else begin
              m_pc = m_stk.pop_back();
              m_depth--;
              m_cyc += 2;
            end
          end
        endcase
      end

      if (m_halt) begin
        do_reset();
        exec_done = 1'b1;
        cyc = 0;
        while (halted !== 1'b1 && cyc < 2000) begin
          tick();
          cyc++;
        end
        exec_done = 1'b0;
        checks++;
        if (cyc != m_cyc) begin
          errors++;
          $display("FAIL rnd_cycles[%0d]: got %0d cycles to halt expected %0d", p, cyc, m_cyc);
        end
      end

      do_reset();
      got_q.delete();
      cyc  = 0;
      done = (!m_halt && exp_q.size() == 0);
      while (!done && cyc < 3000) begin
        exec_done = 1'($urandom_range(0, 1));
        stall     = ($urandom_range(0, 3) == 0);
        #1;
        if (ins_valid === 1'b1 && exec_done === 1'b1) got_q.push_back({ir, operand});
        tick();
        cyc++;
        done = m_halt ? (halted === 1'b1) : (got_q.size() >= exp_q.size());
      end
      stall     = 1'b0;
      exec_done = 1'b0;

      checks++;
      if (!done) begin
        errors++;
        $display("FAIL rnd_timeout[%0d]: got no completion in %0d cycles expected completion", p, cyc);
      end
      checks++;
      if (got_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rnd_count[%0d]: got %0d issues expected %0d", p, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rnd_issue[%0d.%0d]: got ir/operand %h expected %h", p, i, got_q[i], exp_q[i]);
        end
      end
      if (m_halt) begin
        checks++;
        if ({halted, err, depth} !== {1'b1, m_err, 4'(m_depth)}) begin
          errors++;
          $display("FAIL rnd_final[%0d]: got halted/err/depth %b/%0d expected %b/%0d",
                   p, {halted, err}, depth, {1'b1, m_err}, m_depth);
        end
      end
    end

    checks++;
    if (inv_viol != 0) begin
      errors++;
      $display("FAIL pc_cmd_exclusive: got %0d cycles with overlapping commands expected 0", inv_viol);
    end
  endtask

  initial begin
    rst       = 1'b0;
    stall     = 1'b0;
    exec_done = 1'b0;
    clear_rom();
    test_reset();
    test_alu();
    test_jmp();
    test_call_ret();
    test_overflow();
    test_reset();
    test_underflow();
    test_stall();
    test_reset_mid();
    test_random(14);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
